if_id_flush_reg: RTL

- Parametrised IF/ID pipeline register for the MIPS pipeline.
- Supports stall (hold), flush-to-NOP from several sources (eret, exception, branch-squash), and a multi-cycle bubble window after a flush.
- Replaces the ad-hoc combinational NOP substitution at decode with a registered, counted bubble mechanism. It also exports a valid bit so downstream stages can distinguish real NOPs from bubbles.

---
 rtl/if_id_flush_reg.sv | 99 +++++++++
 1 files changed

// File: rtl/if_id_flush_reg.sv
// if_id_flush_reg: IF/ID pipeline register with stall, multi-source flush and counted bubble window; ports clk/reset/stall/eret_d/flush_req/instr_in/pc_in -> instr_out/pc_out/valid_out/busy (+bubble_cnt with IF_ID_BUBBLE_STAT_EN)
module if_id_flush_reg #(
  parameter int                 INSTR_W       = 32,
  parameter int                 PC_W          = 32,
  parameter logic [INSTR_W-1:0] NOP_WORD      = 32'h0000_0000,
  parameter logic [PC_W-1:0]    RESET_PC      = 32'h0000_3000,
  parameter int                 NUM_FLUSH     = 2,
  parameter int                 BUBBLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 eret_d,
  input  logic [NUM_FLUSH-1:0] flush_req,
  input  logic [INSTR_W-1:0]   instr_in,
  input  logic [PC_W-1:0]      pc_in,
  output logic [INSTR_W-1:0]   instr_out,
  output logic [PC_W-1:0]      pc_out,
  output logic                 valid_out,
  output logic                 busy
`ifdef IF_ID_BUBBLE_STAT_EN
  ,
  output logic [31:0]          bubble_cnt
`endif
);
  localparam int CW = BUBBLE_CYCLES > 2 ? $clog2(BUBBLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(BUBBLE_CYCLES > 1 ? BUBBLE_CYCLES - 2 : 0);
  typedef enum logic [1:0] {IDLE = 2'd0, BUBBLE = 2'd1} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               flush, legal, nop_load;
  assign flush    = eret_d | (|flush_req);
  assign legal    = (state_q == IDLE) || (state_q == BUBBLE);
  assign nop_load = legal && (flush || state_q == BUBBLE);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    if (!legal) begin
      state_d = IDLE;
    end else if (flush) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      pc_d    = pc_in;
      state_d = BUBBLE_CYCLES > 1 ? BUBBLE : IDLE;
      cnt_d   = CNT_INIT;
      busy_d  = BUBBLE_CYCLES > 1;
    end else if (state_q == BUBBLE) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      state_d = cnt_q == '0 ? IDLE : BUBBLE;
      cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
      busy_d  = cnt_q != '0;
    end else if (!stall) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      instr_q <= NOP_WORD;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    instr_out = instr_q;
    pc_out    = pc_q;
    valid_out = valid_q;
    busy      = busy_q;
  end
`ifdef IF_ID_BUBBLE_STAT_EN
  logic [31:0] stat_q, stat_d;
  always_comb stat_d = (nop_load && stat_q != '1) ? stat_q + 32'd1 : stat_q;
  always_ff @(posedge clk) begin
    if (reset) stat_q <= '0;
    else stat_q <= stat_d;
  end
  assign bubble_cnt = stat_q;
`endif
endmodule
